key_debounce: RTL and testbench

Multi-key input conditioner for the board push-buttons: synchronises raw active-low key pins, debounces each key with its own state machine, and produces clean level, press, release and long-press outputs. It is the input-side counterpart to the LED pattern drivers. Its one-cycle event pulses are what mode/pattern-select logic consumes.

---
 rtl/key_debounce.sv | 170 +++++++++++++++++
 tb/tb_key_debounce.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// key_debounce
// Multi-key push-button conditioner. Each raw active-low key pin is passed
// through a two-flop synchroniser, inverted to a "pressed" level, and then
// debounced by its own four-state machine. The block produces a clean
// debounced level plus one-cycle press, release and long-press pulses.
//
// Ports:
//   clk50m      in   1        system clock
//   rst         in   1        synchronous reset, active-high
//   key_n       in   KEY_NUM  raw key pins, asynchronous, 0 = pressed
//   key_state   out  KEY_NUM  debounced level, 1 = pressed
//   key_press   out  KEY_NUM  one-cycle pulse on accepted press
//   key_release out  KEY_NUM  one-cycle pulse on accepted release
//   key_long    out  KEY_NUM  one-cycle pulse after LONG_CYC cycles held
//   dbg_state   out  2*KEY_NUM  per-key FSM state, key i at [2*i +: 2]
//                             (0 IDLE, 1 PRESS_FILT, 2 DOWN, 3 REL_FILT)
//
// Handshake: none. Inputs are free-running levels; every output is a
// registered level or a registered single-cycle pulse, valid every cycle.
module key_debounce #(
  parameter int KEY_NUM      = 4,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000
) (
  input  logic                   clk50m,
  input  logic                   rst,
  input  logic [KEY_NUM-1:0]     key_n,
  output logic [KEY_NUM-1:0]     key_state,
  output logic [KEY_NUM-1:0]     key_press,
  output logic [KEY_NUM-1:0]     key_release,
  output logic [KEY_NUM-1:0]     key_long,
  output logic [2*KEY_NUM-1:0]   dbg_state
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int LW = $clog2(LONG_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [LW-1:0] LCNT_MAX = LW'(LONG_CYC);
  localparam logic [LW-1:0] LCNT_PRE = LW'(LONG_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_FILT = 2'd1,
    ST_DOWN       = 2'd2,
    ST_REL_FILT   = 2'd3
  } state_t;

  // Synchroniser resets to all-ones so a reset looks like "all released";
  // a key still held after reset is then seen as a fresh press.
  logic [KEY_NUM-1:0] r_sync1;
  logic [KEY_NUM-1:0] r_sync2;
  logic [KEY_NUM-1:0] w_pressed;

  always_ff @(posedge clk50m) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = ~r_sync2;

  for (genvar gi = 0; gi < KEY_NUM; gi++) begin : g_key
    state_t          r_fsm;
    state_t          w_fsm_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [LW-1:0]   r_lcnt;
    logic [LW-1:0]   w_lcnt_nxt;
    logic            r_lvl;
    logic            w_lvl_nxt;
    logic            r_press;
    logic            w_press_nxt;
    logic            r_rel;
    logic            w_rel_nxt;
    logic            r_long;
    logic            w_long_nxt;

    always_ff @(posedge clk50m) begin
      if (rst) begin
        r_fsm   <= ST_IDLE;
        r_cnt   <= '0;
        r_lcnt  <= '0;
        r_lvl   <= 1'b0;
        r_press <= 1'b0;
        r_rel   <= 1'b0;
        r_long  <= 1'b0;
      end else begin
        r_fsm   <= w_fsm_nxt;
        r_cnt   <= w_cnt_nxt;
        r_lcnt  <= w_lcnt_nxt;
        r_lvl   <= w_lvl_nxt;
        r_press <= w_press_nxt;
        r_rel   <= w_rel_nxt;
        r_long  <= w_long_nxt;
      end
    end

    always_comb begin
      w_fsm_nxt   = r_fsm;
      w_cnt_nxt   = r_cnt;
      w_lcnt_nxt  = r_lcnt;
      w_lvl_nxt   = r_lvl;
      w_press_nxt = 1'b0;
      w_rel_nxt   = 1'b0;
      w_long_nxt  = 1'b0;

      // Hold time keeps accumulating through a release filter so a bounce
      // while held does not restart the long-press timer. Saturation makes
      // the long pulse fire at most once per press.
      if (r_fsm == ST_DOWN || r_fsm == ST_REL_FILT) begin
        if (r_lcnt != LCNT_MAX) begin
          w_lcnt_nxt = r_lcnt + LW'(1);
        end
        w_long_nxt = (r_lcnt == LCNT_PRE);
      end

      case (r_fsm)
        ST_IDLE: begin
          if (w_pressed[gi]) begin
            w_fsm_nxt = ST_PRESS_FILT;
            w_cnt_nxt = '0;
          end
        end
        ST_PRESS_FILT: begin
          if (!w_pressed[gi]) begin
            w_fsm_nxt = ST_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            w_fsm_nxt   = ST_DOWN;
            w_press_nxt = 1'b1;
            w_lvl_nxt   = 1'b1;
            w_lcnt_nxt  = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        ST_DOWN: begin
          if (!w_pressed[gi]) begin
            w_fsm_nxt = ST_REL_FILT;
            w_cnt_nxt = '0;
          end
        end
        ST_REL_FILT: begin
          if (w_pressed[gi]) begin
            w_fsm_nxt = ST_DOWN;
          end else if (r_cnt == CNT_LAST) begin
            w_fsm_nxt = ST_IDLE;
            w_rel_nxt = 1'b1;
            w_lvl_nxt = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: begin
          w_fsm_nxt = ST_IDLE;
        end
      endcase
    end

    assign key_state[gi]           = r_lvl;
    assign key_press[gi]           = r_press;
    assign key_release[gi]         = r_rel;
    assign key_long[gi]            = r_long;
    assign dbg_state[2*gi +: 2]    = r_fsm;
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce
// Table-driven bench for key_debounce with DEBOUNCE_CYC=4, LONG_CYC=20.
// Each scenario fills a per-edge table of {rst, key_n, expected outputs};
// expected outputs are written from the documented latencies (press/release
// at first-sample edge + 6, long at press edge + 20). Vectors are driven on
// the falling edge, the expected word is queued, and after the following
// rising edge (+1) the queue head is popped and compared.
module tb_key_debounce;

  localparam int KN   = 4;
  localparam int DC   = 4;
  localparam int LC   = 20;
  localparam int MAXV = 64;

  typedef struct {
    logic          rst;
    logic [KN-1:0] key_n;
    logic [KN-1:0] st;
    logic [KN-1:0] pr;
    logic [KN-1:0] rl;
    logic [KN-1:0] lg;
  } vec_t;

  // clock / reset
  logic            clk50m = 1'b0;
  logic            rst    = 1'b1;
  logic [KN-1:0]   key_n  = '1;
  logic [KN-1:0]   key_state;
  logic [KN-1:0]   key_press;
  logic [KN-1:0]   key_release;
  logic [KN-1:0]   key_long;
  logic [2*KN-1:0] dbg_state;

  always #5 clk50m = ~clk50m;

  key_debounce #(
    .KEY_NUM      (KN),
    .DEBOUNCE_CYC (DC),
    .LONG_CYC     (LC)
  ) dut (
    .clk50m      (clk50m),
    .rst         (rst),
    .key_n       (key_n),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long),
    .dbg_state   (dbg_state)
  );

  // scoreboard
  logic [4*KN-1:0] exp_q[$];
  vec_t            vecs[MAXV];
  int              nvec;
  int              checks   = 0;
  int              failures = 0;

  // table builders; edge index 0 is the first rising edge of the scenario
  task automatic clear_vecs(input int n);
    nvec = n;
    for (int c = 0; c < MAXV; c++) begin
      vecs[c].rst   = (c < 3);
      vecs[c].key_n = '1;
      vecs[c].st    = '0;
      vecs[c].pr    = '0;
      vecs[c].rl    = '0;
      vecs[c].lg    = '0;
    end
  endtask

  task automatic key_low(input int k, input int from, input int to);
    for (int c = from; c < to && c < nvec; c++) vecs[c].key_n[k] = 1'b0;
  endtask

  task automatic set_rst(input int from, input int to);
    for (int c = from; c < to && c < nvec; c++) vecs[c].rst = 1'b1;
  endtask

  task automatic exp_level(input int k, input int from, input int to);
    for (int c = from; c < to && c < nvec; c++) vecs[c].st[k] = 1'b1;
  endtask

  // kind: 0 press, 1 release, 2 long
  task automatic exp_pulse(input int kind, input int k, input int c);
    if (c < nvec) begin
      case (kind)
        0:       vecs[c].pr[k] = 1'b1;
        1:       vecs[c].rl[k] = 1'b1;
        default: vecs[c].lg[k] = 1'b1;
      endcase
    end
  endtask

  // driver + monitor
  task automatic run_vectors(input string name);
    logic [4*KN-1:0] got;
    logic [4*KN-1:0] exp;
    for (int c = 0; c < nvec; c++) begin
      @(negedge clk50m);
      rst   = vecs[c].rst;
      key_n = vecs[c].key_n;
      exp_q.push_back({vecs[c].st, vecs[c].pr, vecs[c].rl, vecs[c].lg});
      @(posedge clk50m);
      #1;
      got = {key_state, key_press, key_release, key_long};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s edge=%0d got st/pr/rl/lg=%b_%b_%b_%b exp=%b_%b_%b_%b",
                 name, c, got[15:12], got[11:8], got[7:4], got[3:0],
                 exp[15:12], exp[11:8], exp[7:4], exp[3:0]);
      end
    end
  endtask

  initial begin
    // reset with key0 already held: outputs 0 during reset, press at r+6
    clear_vecs(14);
    key_low(0, 0, 14);
    exp_pulse(0, 0, 9);
    exp_level(0, 9, 14);
    run_vectors("reset_held");

    // clean press / hold / release on key0, single long pulse
    clear_vecs(60);
    key_low(0, 10, 50);
    exp_pulse(0, 0, 16);
    exp_level(0, 16, 56);
    exp_pulse(2, 0, 36);
    exp_pulse(1, 0, 56);
    run_vectors("clean_key0");

    // press bounce on key1 rejected, then steady press accepted
    clear_vecs(30);
    key_low(1, 5, 9);
    key_low(1, 11, 14);
    key_low(1, 20, 30);
    exp_pulse(0, 1, 26);
    exp_level(1, 26, 30);
    run_vectors("press_bounce_key1");

    // release glitch of 3 cycles on key2 rejected; long still at press+20
    clear_vecs(45);
    key_low(2, 5, 15);
    key_low(2, 18, 35);
    exp_pulse(0, 2, 11);
    exp_level(2, 11, 41);
    exp_pulse(2, 2, 31);
    exp_pulse(1, 2, 41);
    run_vectors("release_glitch_key2");

    // key0 and key3 pressed and released together
    clear_vecs(30);
    key_low(0, 5, 20);
    key_low(3, 5, 20);
    exp_pulse(0, 0, 11);
    exp_pulse(0, 3, 11);
    exp_level(0, 11, 26);
    exp_level(3, 11, 26);
    exp_pulse(1, 0, 26);
    exp_pulse(1, 3, 26);
    run_vectors("simultaneous_k0_k3");

    // reset two cycles into key1 press filter aborts; re-press after reset
    clear_vecs(22);
    key_low(1, 5, 22);
    set_rst(9, 11);
    exp_pulse(0, 1, 17);
    exp_level(1, 17, 22);
    run_vectors("reset_mid_filter");

    // long pulse coincides with release on key0; 5-cycle key3 press accepted
    clear_vecs(36);
    key_low(0, 5, 25);
    exp_pulse(0, 0, 11);
    exp_level(0, 11, 31);
    exp_pulse(2, 0, 31);
    exp_pulse(1, 0, 31);
    key_low(3, 5, 10);
    exp_pulse(0, 3, 11);
    exp_level(3, 11, 16);
    exp_pulse(1, 3, 16);
    run_vectors("long_with_release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
